// File: rtl/pio_edge_keys_pkg.sv
// pio_edge_keys_pkg
//   Shared constants for the debounced edge-capture PIO: Avalon-MM register
//   addresses, EDGE_TYPE encodings, stability-counter sizing and the edge
//   qualification helper used by the top level.
package pio_edge_keys_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_DBRELOAD = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int STAB_W = 2;
  // Count value at which the next differing tick makes the count reach 3,
  // i.e. the tick on which the new level is accepted.
  localparam logic [STAB_W-1:0] STAB_COMMIT = 2'd2;

  function automatic logic edge_hit(input int edge_type, input logic cur,
                                    input logic prev);
    case (edge_type)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit
//   One key channel: SYNC_STAGES-deep synchroniser followed by a 2-bit
//   stability counter that only accepts a new level after it has differed
//   from the debounced level on three consecutive prescaler ticks.
// Ports:
//   clk, reset  clock / asynchronous active-high reset
//   din         raw asynchronous key input
//   tick        shared one-cycle prescaler tick
//   bypass      follow the synchronised level every cycle (reload == 0)
//   dout        debounced level
module pio_debounce_bit
  import pio_edge_keys_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic tick,
  input  logic bypass,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   synced;
  logic [STAB_W-1:0]      stab_cnt;
  logic                   deb;

  assign synced = sync_p[SYNC_STAGES-1];
  assign dout   = deb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p   <= {SYNC_STAGES{IDLE_LEVEL}};
      stab_cnt <= '0;
      deb      <= IDLE_LEVEL;
    end else begin
      // stage: synchroniser chain, din enters at bit 0
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
      // stage: stability counter / debounced level
      if (bypass) begin
        deb      <= synced;
        stab_cnt <= '0;
      end else if (synced == deb) begin
        stab_cnt <= '0;
      end else if (tick) begin
        if (stab_cnt == STAB_COMMIT) begin
          deb      <= synced;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pio_edge_keys.sv
// pio_edge_keys
//   Debounced key PIO with edge capture and masked level interrupt on an
//   Avalon-MM slave.
//   Registers: 0 debounced data (RO), 1 debounce reload [15:0] (RW),
//              2 irq_mask [WIDTH-1:0] (RW), 3 edge_capture (W1C).
// Ports:
//   clk, reset                  clock / asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata          Avalon-MM slave write side
//   readdata                    registered read data, 1-cycle latency
//   in_port                     asynchronous key inputs
//   irq                         OR of (edge_capture & irq_mask)
module pio_edge_keys
  import pio_edge_keys_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter int          EDGE_TYPE   = 1,
  parameter int          SYNC_STAGES = 2,
  parameter bit          IDLE_LEVEL  = 1'b1,
  parameter logic [15:0] DB_RESET    = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             wr_en;
  logic             wr_reload;
  logic             wr_mask;
  logic [WIDTH-1:0] cap_clr;
  logic [15:0]      reload_r;
  logic [15:0]      presc_r;
  logic             tick;
  logic             bypass;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_r;
  logic [WIDTH-1:0] mask_r;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_reload = wr_en && (address == ADDR_DBRELOAD);
  assign wr_mask   = wr_en && (address == ADDR_IRQMASK);
  assign cap_clr   = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
  assign tick      = (presc_r == 16'd0);
  assign bypass    = (reload_r == 16'd0);
  assign irq       = |(cap_r & mask_r);
  // Upper write bits only matter for wide mask/capture configurations.
  assign unused_wdata = ^writedata[31:16];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .tick  (tick),
      .bypass(bypass),
      .dout  (deb[i])
    );
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      edge_det[i] = edge_hit(EDGE_TYPE, deb[i], prev_r[i]);
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next[WIDTH-1:0] = deb;
      ADDR_DBRELOAD: rd_next[15:0]      = reload_r;
      ADDR_IRQMASK:  rd_next[WIDTH-1:0] = mask_r;
      default:       rd_next[WIDTH-1:0] = cap_r;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_r <= DB_RESET;
      presc_r  <= DB_RESET;
      mask_r   <= '0;
      cap_r    <= '0;
      prev_r   <= {WIDTH{IDLE_LEVEL}};
      readdata <= '0;
    end else begin
      // stage: register read and edge capture (set beats write-1-to-clear)
      readdata <= rd_next;
      prev_r   <= deb;
      cap_r    <= (cap_r & ~cap_clr) | edge_det;
      if (wr_mask) mask_r <= writedata[WIDTH-1:0];
      // stage: debounce prescaler; a reload write restarts it immediately
      if (wr_reload) begin
        reload_r <= writedata[15:0];
        presc_r  <= writedata[15:0];
      end else if (tick) begin
        presc_r <= reload_r;
      end else begin
        presc_r <= presc_r - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pio_edge_keys.sv
// tb_pio_edge_keys
//   Two instances: u_fall (defaults, falling-edge capture) and u_any
//   (any-edge capture, small reset reload). A cycle-level behavioural model
//   predicts readdata and irq of both every cycle; directed sequences add
//   constant expectations for the key scenarios.
module tb_pio_edge_keys;

  localparam int N = 2;
  localparam int S = 2;
  localparam int ETYPE [N] = '{1, 2};
  localparam int DBR   [N] = '{50000, 5};

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address    [N];
  logic        chipselect [N];
  logic        write_n    [N];
  logic [31:0] writedata  [N];
  logic [3:0]  in_port    [N];
  logic [31:0] readdata   [N];
  logic        irq        [N];

  int checks = 0;
  int errors = 0;

  // model state
  int         m_presc  [N];
  int         m_reload [N];
  logic [3:0] m_hist   [N][S];
  int         m_cnt    [N][4];
  logic [3:0] m_deb    [N];
  logic [3:0] m_prev   [N];
  logic [3:0] m_cap    [N];
  logic [3:0] m_mask   [N];
  logic [31:0] m_rd    [N];

  always #5 clk = ~clk;

  pio_edge_keys u_fall (
    .clk(clk), .reset(reset), .address(address[0]), .chipselect(chipselect[0]),
    .write_n(write_n[0]), .writedata(writedata[0]), .in_port(in_port[0]),
    .readdata(readdata[0]), .irq(irq[0])
  );

  pio_edge_keys #(.EDGE_TYPE(2), .DB_RESET(16'd5)) u_any (
    .clk(clk), .reset(reset), .address(address[1]), .chipselect(chipselect[1]),
    .write_n(write_n[1]), .writedata(writedata[1]), .in_port(in_port[1]),
    .readdata(readdata[1]), .irq(irq[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_presc[d]  = DBR[d];
    m_reload[d] = DBR[d];
    for (int k = 0; k < S; k++) m_hist[d][k] = 4'hF;
    for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
    m_deb[d]  = 4'hF;
    m_prev[d] = 4'hF;
    m_cap[d]  = 4'h0;
    m_mask[d] = 4'h0;
    m_rd[d]   = 32'h0;
  endtask

  // Advance one clock from the register values and inputs seen before the edge.
  task automatic model_step(input int d);
    logic [3:0] synced, ndeb, edges, clr;
    bit tick, byp, wr;
    synced = m_hist[d][S-1];
    tick   = (m_presc[d] == 0);
    byp    = (m_reload[d] == 0);
    wr     = chipselect[d] && !write_n[d];
    case (address[d])
      2'd0:    m_rd[d] = {28'h0, m_deb[d]};
      2'd1:    m_rd[d] = 32'(m_reload[d]);
      2'd2:    m_rd[d] = {28'h0, m_mask[d]};
      default: m_rd[d] = {28'h0, m_cap[d]};
    endcase
    ndeb = m_deb[d];
    for (int c = 0; c < 4; c++) begin
      if (byp) begin
        ndeb[c] = synced[c];
        m_cnt[d][c] = 0;
      end else if (synced[c] == m_deb[d][c]) begin
        m_cnt[d][c] = 0;
      end else if (tick) begin
        m_cnt[d][c]++;
        if (m_cnt[d][c] == 3) begin
          ndeb[c] = synced[c];
          m_cnt[d][c] = 0;
        end
      end
    end
    case (ETYPE[d])
      0:       edges = m_deb[d] & ~m_prev[d];
      1:       edges = ~m_deb[d] & m_prev[d];
      default: edges = m_deb[d] ^ m_prev[d];
    endcase
    clr = (wr && address[d] == 2'd3) ? writedata[d][3:0] : 4'h0;
    m_cap[d]  = (m_cap[d] & ~clr) | edges;
    m_prev[d] = m_deb[d];
    m_deb[d]  = ndeb;
    if (wr && address[d] == 2'd1) m_presc[d] = int'(writedata[d][15:0]);
    else if (m_presc[d] == 0)     m_presc[d] = m_reload[d];
    else                          m_presc[d] = m_presc[d] - 1;
    if (wr && address[d] == 2'd1) m_reload[d] = int'(writedata[d][15:0]);
    if (wr && address[d] == 2'd2) m_mask[d] = writedata[d][3:0];
    for (int k = S - 1; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
    m_hist[d][0] = in_port[d];
  endtask

  task automatic tick_clk();
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      if (reset) model_reset(d);
      else model_step(d);
    end
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      chk($sformatf("model_rd%0d", d), readdata[d], m_rd[d]);
      chk($sformatf("model_irq%0d", d), 32'(irq[d]), 32'(|(m_cap[d] & m_mask[d])));
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic write_reg(input int d, input logic [1:0] a, input logic [31:0] v);
    chipselect[d] = 1'b1;
    write_n[d]    = 1'b0;
    address[d]    = a;
    writedata[d]  = v;
    tick_clk();
    chipselect[d] = 1'b0;
    write_n[d]    = 1'b1;
  endtask

  task automatic read_reg(input int d, input logic [1:0] a, input logic [31:0] exp,
                          input string tag);
    address[d] = a;
    tick_clk();
    chk(tag, readdata[d], exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1'b1;
    for (int d = 0; d < N; d++) begin
      address[d] = 2'd0; chipselect[d] = 1'b0; write_n[d] = 1'b1;
      writedata[d] = 32'h0; in_port[d] = 4'hF;
      model_reset(d);
    end
    wait_cycles(3);
    chk("rst_readdata", readdata[0], 32'h0);
    chk("rst_irq", 32'(irq[0]), 32'h0);
    reset = 1'b0;

    // reset register values
    read_reg(0, 2'd1, 32'd50000, "rst_reload");
    read_reg(0, 2'd0, 32'hF, "rst_data");
    read_reg(0, 2'd2, 32'h0, "rst_mask");
    read_reg(0, 2'd3, 32'h0, "rst_cap");
    read_reg(1, 2'd1, 32'd5, "rst_reload_any");

    // bypass: falling edge on bit0 reaches irq within SYNC_STAGES+2 cycles
    write_reg(0, 2'd1, 32'h0);
    write_reg(0, 2'd2, 32'hF);
    in_port[0] = 4'hE;
    seen = 1'b0;
    for (int i = 0; i < S + 2; i++) begin
      tick_clk();
      if (irq[0]) begin seen = 1'b1; break; end
    end
    chk("byp_irq_wait", 32'(seen), 32'h1);
    read_reg(0, 2'd3, 32'h1, "byp_cap");
    write_reg(0, 2'd3, 32'h1);
    chk("byp_clr_irq", 32'(irq[0]), 32'h0);
    in_port[0] = 4'hF;
    wait_cycles(6);
    read_reg(0, 2'd3, 32'h0, "byp_rise_ignored");

    // debounce: short glitch rejected, long hold accepted
    write_reg(0, 2'd1, 32'd3);
    in_port[0] = 4'hE;
    wait_cycles(6);
    in_port[0] = 4'hF;
    wait_cycles(12);
    read_reg(0, 2'd3, 32'h0, "db_glitch_cap");
    read_reg(0, 2'd0, 32'hF, "db_glitch_data");
    in_port[0] = 4'hE;
    wait_cycles(20);
    read_reg(0, 2'd0, 32'hE, "db_hold_data");
    read_reg(0, 2'd3, 32'h1, "db_hold_cap");
    chk("db_hold_irq", 32'(irq[0]), 32'h1);
    write_reg(0, 2'd3, 32'h1);
    in_port[0] = 4'hF;
    wait_cycles(20);
    read_reg(0, 2'd3, 32'h0, "db_release_cap");

    // mask: bits 1 and 2 captured, only bit 1 enabled
    write_reg(0, 2'd1, 32'h0);
    write_reg(0, 2'd2, 32'h2);
    in_port[0] = 4'h9;
    wait_cycles(6);
    read_reg(0, 2'd3, 32'h6, "mask_cap");
    chk("mask_irq_on", 32'(irq[0]), 32'h1);
    write_reg(0, 2'd2, 32'h0);
    chk("mask_irq_off", 32'(irq[0]), 32'h0);
    read_reg(0, 2'd3, 32'h6, "mask_cap_kept");
    write_reg(0, 2'd3, 32'h6);
    in_port[0] = 4'hF;
    wait_cycles(6);

    // clear and set of bit3 on the same edge: set wins
    in_port[0] = 4'h7;
    wait_cycles(S + 1);
    write_reg(0, 2'd3, 32'h8);
    read_reg(0, 2'd3, 32'h8, "set_beats_clr");
    write_reg(0, 2'd3, 32'h8);
    in_port[0] = 4'hF;
    wait_cycles(6);
    read_reg(0, 2'd3, 32'h0, "clr_after_set");

    // any-edge instance: both edges captured, re-set after a clear
    write_reg(1, 2'd1, 32'h0);
    in_port[1] = 4'hE;
    wait_cycles(5);
    read_reg(1, 2'd3, 32'h1, "any_fall");
    write_reg(1, 2'd3, 32'h1);
    read_reg(1, 2'd3, 32'h0, "any_cleared");
    in_port[1] = 4'hF;
    wait_cycles(5);
    read_reg(1, 2'd3, 32'h1, "any_rise");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < N; d++) begin
        chipselect[d] = 1'b0;
        write_n[d]    = 1'b1;
        if ($urandom_range(0, 7) == 0) in_port[d] = in_port[d] ^ 4'($urandom_range(1, 15));
        address[d] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) begin
          chipselect[d] = 1'($urandom_range(0, 1));
          write_n[d]    = 1'($urandom_range(0, 1));
          writedata[d]  = (address[d] == 2'd1) ? 32'($urandom_range(0, 3)) : $urandom();
        end
      end
      tick_clk();
    end
    for (int d = 0; d < N; d++) begin
      chipselect[d] = 1'b0; write_n[d] = 1'b1; in_port[d] = 4'hF;
    end
    wait_cycles(4);

    // reset in the middle of a debounce count
    write_reg(0, 2'd1, 32'd3);
    write_reg(0, 2'd2, 32'hF);
    in_port[0] = 4'hE;
    wait_cycles(6);
    reset = 1'b1;
    for (int d = 0; d < N; d++) model_reset(d);
    in_port[0] = 4'hF;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(10);
    chk("mid_rst_irq", 32'(irq[0]), 32'h0);
    read_reg(0, 2'd0, 32'hF, "mid_rst_data");
    read_reg(0, 2'd1, 32'd50000, "mid_rst_reload");
    read_reg(0, 2'd2, 32'h0, "mid_rst_mask");
    read_reg(0, 2'd3, 32'h0, "mid_rst_cap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
